// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-to-UART transmitter: state encoding,
// frame constants and the baud counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    STOP  = 3'd6
  } uartState_t;

  localparam int DATA_BITS = 8;

  function automatic int baudCntWidth(input int baudDiv);
    return (baudDiv < 2) ? 1 : $clog2(baudDiv);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: counts 0..BAUD_DIV-1, wraps on its own tick and can be
// cleared synchronously whenever the transmitter changes state.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter  int BAUD_DIV = 434,
  localparam int CW       = baudCntWidth(BAUD_DIV)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clear,
  output logic          o_tick,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;
  logic          w_tick;

  assign w_tick  = (r_count == CW'(BAUD_DIV - 1));
  assign o_tick  = w_tick;
  assign o_count = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear || w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the sample FIFO and sends them as 8N1 UART frames, LSB first.
// Defining UART_PARITY_EN inserts an even-parity bit, giving 8E1 frames.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       empty,
  input  logic [7:0] q,
  output logic       rdreq,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int CW = baudCntWidth(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS);

  if (BAUD_DIV < 2) begin : g_badBaudDiv
    $error("fifo_uart_tx: BAUD_DIV must be at least 2");
  end

  uartState_t           r_state;
  uartState_t           w_nextState;
  logic                 r_emptyS;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shiftNext;
  logic [BW-1:0]        r_bitCnt;
  logic [BW-1:0]        w_bitCntNext;
  logic                 r_tx;
  logic                 r_rdreq;
  logic                 r_busy;
  logic                 r_byteDone;
  logic                 w_txNext;
  logic                 w_tick;
  logic                 w_clear;
  logic [CW-1:0]        w_baudCnt;
`ifdef UART_PARITY_EN
  logic                 r_parity;
`endif

  assign w_clear = (w_nextState != r_state);

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baudTick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .o_tick  (w_tick),
    .o_count (w_baudCnt)
  );

  always_comb begin
    w_nextState  = r_state;
    w_shiftNext  = r_shift;
    w_bitCntNext = r_bitCnt;
    w_txNext     = 1'b1;
    case (r_state)
      IDLE:  if (!r_emptyS) w_nextState = RD;
      RD:    w_nextState = LATCH;
      LATCH: begin
        w_shiftNext = q;
        w_nextState = START;
      end
      START: if (w_tick) w_nextState = DATA;
      DATA: begin
        if (w_tick) begin
          w_shiftNext = r_shift >> 1;
          if (r_bitCnt == BW'(DATA_BITS - 1)) begin
            w_bitCntNext = '0;
`ifdef UART_PARITY_EN
            w_nextState  = PAR;
`else
            w_nextState  = STOP;
`endif
          end else begin
            w_bitCntNext = r_bitCnt + BW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PAR:   if (w_tick) w_nextState = STOP;
`endif
      STOP:  if (w_tick) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase

    // Line level is decided from the state being entered so tx stays registered.
    case (w_nextState)
      START: w_txNext = 1'b0;
      DATA:  w_txNext = w_shiftNext[0];
`ifdef UART_PARITY_EN
      PAR:   w_txNext = r_parity;
`endif
      default: w_txNext = 1'b1;
    endcase
  end

  // empty is sampled one edge early, which gives q time to settle before LATCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_emptyS   <= 1'b1;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_tx       <= 1'b1;
      r_rdreq    <= 1'b0;
      r_busy     <= 1'b0;
      r_byteDone <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_emptyS   <= empty;
      r_shift    <= w_shiftNext;
      r_bitCnt   <= w_bitCntNext;
      r_tx       <= w_txNext;
      r_rdreq    <= (w_nextState == RD);
      r_busy     <= (w_nextState != IDLE);
      r_byteDone <= (r_state == STOP) && (w_baudCnt == CW'(BAUD_DIV - 2));
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (r_state == LATCH) begin
      r_parity <= ^q;
    end
  end
`endif

  assign rdreq     = r_rdreq;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign byte_done = r_byteDone;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-backed FIFO feeds the transmitter and a
// frame-level model predicts tx, rdreq, busy and byte_done on every cycle.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int BD       = CLK_FREQ / BAUD;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam logic [10:0] A5_BITS = 11'b10101001010;
`else
  localparam int FRAME_BITS = 10;
  localparam logic [10:0] A5_BITS = 11'b11101001010;
`endif
  localparam int FRAME_LEN = FRAME_BITS * BD;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       empty;
  logic [7:0] q;
  logic       rdreq;
  logic       tx;
  logic       busy;
  logic       byte_done;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          rdCount     = 0;
  int          rdCycs[$];
  logic [7:0]  fifoQ[$];
  logic        forceEmpty;
  logic        sawRd;

  logic        mActive = 1'b0;
  int          mStart  = 0;
  logic [10:0] mBits   = '1;

  fifo_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .empty     (empty),
    .q         (q),
    .rdreq     (rdreq),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] frameBits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Normal-mode FIFO: a read seen at an edge presents the popped byte just after it.
  initial begin
    q     = 8'h00;
    empty = 1'b1;
    forever begin
      @(posedge clk);
      sawRd = rdreq;
      #1;
      if (sawRd === 1'b1 && fifoQ.size() > 0) q = fifoQ.pop_front();
      empty = forceEmpty || (fifoQ.size() == 0);
    end
  end

  // Frame model: empty seen low at edge N while idle means a frame on the line from N+3.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset_n !== 1'b1) begin
        mActive = 1'b0;
      end else begin
        if (mActive && cyc == mStart + FRAME_LEN) mActive = 1'b0;
        if (!mActive && empty === 1'b0) begin
          mActive = 1'b1;
          mStart  = cyc + 3;
          mBits   = frameBits(fifoQ[0]);
        end
      end
    end
  end

  initial begin
    logic expTx, expRd, expBusy, expDone;
    forever begin
      @(negedge clk);
      if (rdreq === 1'b1) begin
        rdCount++;
        rdCycs.push_back(cyc);
      end
      expTx = 1'b1; expRd = 1'b0; expBusy = 1'b0; expDone = 1'b0;
      if (reset_n === 1'b1 && mActive) begin
        expRd   = (cyc == mStart - 2);
        expBusy = (cyc >= mStart - 2) && (cyc < mStart + FRAME_LEN);
        expDone = (cyc == mStart + FRAME_LEN - 1);
        if (cyc >= mStart && cyc < mStart + FRAME_LEN) expTx = mBits[(cyc - mStart) / BD];
      end
      checkOutput("tx", {31'd0, tx}, {31'd0, expTx});
      checkOutput("rdreq", {31'd0, rdreq}, {31'd0, expRd});
      checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
      checkOutput("byte_done", {31'd0, byte_done}, {31'd0, expDone});
    end
  end

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || fifoQ.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drainInTime", {31'd0, n < budget}, 32'd1);
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic checkFrameLiteral(input logic [7:0] b, input logic [10:0] expBits,
                                   input string tag);
    int n = 0, doneCnt = 0, doneAt = -1, dropAt = -1, startRd;
    startRd = rdCount;
    fifoQ.push_back(b);
    forceEmpty = 1'b0;
    do begin
      @(posedge clk);
      n++;
    end while (empty !== 1'b0 && n < 50);
    checkOutput({tag, "_emptySeen"}, {31'd0, n < 50}, 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, "_rdreqN1"}, {31'd0, rdreq}, 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, "_rdreqN2"}, {31'd0, rdreq}, 32'd0);
    checkOutput({tag, "_txN2"}, {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, "_txFallN3"}, {31'd0, tx}, 32'd0);
    for (int i = 1; i <= FRAME_LEN + 2; i++) begin
      @(posedge clk); #1;
      if (i % BD == BD / 2)
        checkOutput($sformatf("%s_bit%0d", tag, i / BD), {31'd0, tx}, {31'd0, expBits[i / BD]});
      if (byte_done === 1'b1) begin
        doneCnt++;
        if (doneAt < 0) doneAt = i;
      end
      if (busy === 1'b0 && dropAt < 0) dropAt = i;
    end
    checkOutput({tag, "_doneCount"}, doneCnt, 32'd1);
    checkOutput({tag, "_doneAt"}, doneAt, FRAME_LEN - 1);
    checkOutput({tag, "_frameLen"}, dropAt, FRAME_LEN);
    checkOutput({tag, "_oneRead"}, rdCount - startRd, 32'd1);
  endtask

  task automatic applyStimulus(input int testId);
    int n, startRd, lowCnt;
    case (testId)
      0: begin
        forceEmpty = 1'b1;
        startRd    = rdCount;
        lowCnt     = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (tx !== 1'b1) lowCnt++;
        end
        checkOutput("idleNoRdreq", rdCount - startRd, 32'd0);
        checkOutput("idleTxHigh", lowCnt, 32'd0);
        @(posedge clk); #2;
      end
      1: begin
        rdCycs.delete();
        startRd = rdCount;
        fifoQ.push_back(8'h12);
        fifoQ.push_back(8'h0D);
        fifoQ.push_back(8'h0A);
        forceEmpty = 1'b0;
        waitIdle(1000);
        repeat (150) @(posedge clk);
        checkOutput("streamReads", rdCount - startRd, 32'd3);
        if (rdCycs.size() >= 3) begin
          checkOutput("streamSpacing1", rdCycs[1] - rdCycs[0], FRAME_LEN + 3);
          checkOutput("streamSpacing2", rdCycs[2] - rdCycs[1], FRAME_LEN + 3);
        end
        #2;
      end
      2: begin
        startRd = rdCount;
        fifoQ.push_back(8'h5A);
        fifoQ.push_back(8'h3C);
        forceEmpty = 1'b0;
        n = 0;
        do begin
          @(posedge clk);
          n++;
        end while (busy !== 1'b1 && n < 50);
        checkOutput("midBusySeen", {31'd0, n < 50}, 32'd1);
        repeat (40) @(posedge clk);
        #2;
        forceEmpty = 1'b1;
        repeat (FRAME_LEN + 100) @(posedge clk);
        checkOutput("midToggleReads", rdCount - startRd, 32'd1);
        #2;
        forceEmpty = 1'b0;
        waitIdle(500);
      end
      3: begin
        fifoQ.push_back(8'hFF);
        forceEmpty = 1'b0;
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (tx !== 1'b0 && n < 50);
        checkOutput("rstFrameStarted", {31'd0, n < 50}, 32'd1);
        repeat (39) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rstTx", {31'd0, tx}, 32'd1);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstRdreq", {31'd0, rdreq}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        startRd = rdCount;
        lowCnt  = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (tx !== 1'b1) lowCnt++;
        end
        checkOutput("postRstNoRdreq", rdCount - startRd, 32'd0);
        checkOutput("postRstTxHigh", lowCnt, 32'd0);
        @(posedge clk); #2;
      end
      default: begin
        for (int i = 0; i < 3000; i++) begin
          @(posedge clk); #2;
          if ($urandom_range(0, 99) < 3 && fifoQ.size() < 8) fifoQ.push_back(8'($urandom));
          if ($urandom_range(0, 199) == 0) forceEmpty = ~forceEmpty;
        end
        forceEmpty = 1'b0;
        waitIdle(3000);
      end
    endcase
  endtask

  initial begin
    reset_n    = 1'b0;
    forceEmpty = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("resetTx", {31'd0, tx}, 32'd1);
    checkOutput("resetRdreq", {31'd0, rdreq}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetByteDone", {31'd0, byte_done}, 32'd0);
    checkOutput("modelBitsA5", {21'd0, frameBits(8'hA5)}, {21'd0, A5_BITS});
    reset_n = 1'b1;

    applyStimulus(0);
    checkFrameLiteral(8'hA5, A5_BITS, "singleA5");
    waitIdle(200);
`ifdef UART_PARITY_EN
    checkFrameLiteral(8'h07, 11'b11000001110, "parity07");
    waitIdle(200);
    checkFrameLiteral(8'h03, 11'b10000000110, "parity03");
    waitIdle(200);
`endif
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    applyStimulus(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: run did not complete, actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
